fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Instruction fetch and issue stage that sits directly upstream of the halt detector.
- Reads instruction words from program memory through a req/ack handshake and registers the opcode and operand.
- Presents the registered opcode to the halt detector and samples its combinational run-enable result (1 = continue, 0 = halt).
- On continue, issues the instruction to the execution driver through a valid/ready handshake and advances the PC. On halt, parks in HALT until reset or restart.

Parameters:
- ADDR_WIDTH, 8, program-memory address / PC width.
- OPCODE_SIZE, 8, opcode field width (upper bits of the instruction word).
- OPERAND_SIZE, 8, operand field width (lower bits of the instruction word).
- RESET_PC, 0, PC value loaded on reset and on start.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  pulse; begins execution from RESET_PC when in IDLE or HALT.
- mem_req  out  1  fetch request; held high until mem_ack.
- mem_addr  out  ADDR_WIDTH  fetch address (= pc); stable while mem_req is high.
- mem_ack  in  1  read data valid this cycle.
- mem_rdata  in  OPCODE_SIZE+OPERAND_SIZE  instruction word: {opcode, operand}.
- opcode  out  OPCODE_SIZE  registered opcode; drives the halt detector.
- operand  out  OPERAND_SIZE  registered operand.
- run_en  in  1  halt detector result for the current opcode (0 = halt).
- issue_valid  out  1  instruction offered to the execution driver.
- issue_ready  in  1  execution driver accepts the instruction.
- pc  out  ADDR_WIDTH  current program counter.
- halted  out  1  high in HALT.
- busy  out  1  high in FETCH, DECODE or ISSUE.
- issue_count  out  16  count of instructions issued since the last start.

Behaviour:
- Reset (rst=1 at an edge, any state):
  - state=IDLE, pc=RESET_PC, opcode=0, operand=0, issue_count=0.
  - mem_req=0, issue_valid=0, halted=0, busy=0.
  - Mid-transaction reset abandons the fetch or issue; mem_req and issue_valid are low from the next cycle.
  - A mem_ack arriving after reset is ignored.
- States:
  - IDLE: outputs quiet. start -> FETCH; pc=RESET_PC, issue_count=0.
  - FETCH: mem_req=1, mem_addr=pc. When mem_ack=1, latch opcode and operand from mem_rdata -> DECODE. An ack in the first FETCH cycle is legal (zero-wait memory).
  - DECODE: one cycle with opcode stable; run_en is sampled this cycle.
    - run_en=0 -> HALT. pc is unchanged and points at the halt instruction.
    - run_en=1 -> ISSUE.
  - ISSUE: issue_valid=1 with opcode and operand held stable. When issue_ready=1: issue_count+1, pc+1 -> FETCH. If issue_ready is already high on entry, transfer occurs in the first ISSUE cycle.
  - HALT: halted=1, outputs otherwise quiet. start -> FETCH from RESET_PC, issue_count=0.
- Throughput and latency:
  - Fastest loop is 3 cycles per instruction: FETCH (ack same cycle), DECODE, ISSUE (ready high).
  - Latency from start to the first mem_req is 1 cycle.
- Arithmetic:
  - pc increments modulo 2^ADDR_WIDTH; 0xFF+1 wraps to 0x00 with no flag.
  - issue_count saturates at 0xFFFF.
- Ignored inputs:
  - start is ignored while busy.
  - mem_ack outside FETCH and issue_ready outside ISSUE are ignored.
- Simultaneous events: rst overrides start and every handshake in the same cycle.
- Halt instructions are never issued downstream.

Optional Feature:
- Macro: FETCH_SEQUENCER_SINGLE_STEP_EN.
- When defined:
  - Extra input port step (1 bit).
  - After each ISSUE transfer, go to a PAUSE state (busy=0, halted=0) instead of FETCH.
  - A step pulse in PAUSE -> FETCH.
  - start in PAUSE restarts from RESET_PC.
  - rst returns to IDLE.
- When undefined: no step port, no PAUSE state; ISSUE -> FETCH directly.

Test Plan:
- Basic run: memory 0x00:{0x10,0xAA}, 0x01:{0x20,0xBB}, 0x02:{0x01,0x00}; zero-wait memory, ready tied high; start pulse -> two issues (0x10/0xAA, then 0x20/0xBB), then halted=1, pc=0x02, issue_count=2, 0x01 never issued.
- Wait states: mem_ack delayed 3 cycles and issue_ready delayed 2 cycles -> mem_addr stable under mem_req, opcode and operand stable under issue_valid, exactly one issue per instruction.
- Wrap: RESET_PC=0xFE, non-halt opcodes at 0xFE and 0xFF, halt at 0x00 -> fetch sequence 0xFE, 0xFF, 0x00; halted with pc=0x00.
- Reset mid-fetch: rst asserted during FETCH with mem_ack pending -> next cycle mem_req=0, state IDLE, pc=RESET_PC; a late ack causes no issue.
- Restart from halt and busy start: start while busy has no effect; start in HALT -> mem_req at RESET_PC next cycle, issue_count cleared to 0.
- Single step (macro defined): after each issue busy=0 until a step pulse; three step pulses advance three instructions.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// Fetch/issue bus bundle: program-memory req/ack, halt-detector opcode/run_en
// and execution-driver valid/ready, grouped for the fetch_sequencer.
interface fetch_sequencer_if #(
    parameter int ADDR_WIDTH   = 8,
    parameter int OPCODE_SIZE  = 8,
    parameter int OPERAND_SIZE = 8
);
    logic                                mem_req;
    logic [ADDR_WIDTH-1:0]               mem_addr;
    logic                                mem_ack;
    logic [OPCODE_SIZE+OPERAND_SIZE-1:0] mem_rdata;
    logic [OPCODE_SIZE-1:0]              opcode;
    logic [OPERAND_SIZE-1:0]             operand;
    logic                                run_en;
    logic                                issue_valid;
    logic                                issue_ready;

    modport master (
        output mem_req, mem_addr, opcode, operand, issue_valid,
        input  mem_ack, mem_rdata, run_en, issue_ready
    );

    modport slave (
        input  mem_req, mem_addr, opcode, operand, issue_valid,
        output mem_ack, mem_rdata, run_en, issue_ready
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch/decode/issue sequencer feeding the halt detector and execution driver.
// Optional single-step PAUSE state enabled by defining FETCH_SEQUENCER_SINGLE_STEP_EN.
module fetch_sequencer #(
    parameter int                    ADDR_WIDTH   = 8,
    parameter int                    OPCODE_SIZE  = 8,
    parameter int                    OPERAND_SIZE = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC     = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
`ifdef FETCH_SEQUENCER_SINGLE_STEP_EN
    input  logic                   step,
`endif
    fetch_sequencer_if.master      bus,
    output logic [ADDR_WIDTH-1:0]  pc,
    output logic                   halted,
    output logic                   busy,
    output logic [15:0]            issue_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_ISSUE  = 3'd3,
        S_HALT   = 3'd4
`ifdef FETCH_SEQUENCER_SINGLE_STEP_EN
        , S_PAUSE = 3'd5
`endif
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [ADDR_WIDTH-1:0]   r_pc;
    logic [OPCODE_SIZE-1:0]  r_opcode;
    logic [OPERAND_SIZE-1:0] r_operand;
    logic [15:0]             r_issue_count;
    logic                    w_fetch_done;
    logic                    w_issue_fire;
    logic                    w_restart;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign w_fetch_done = (r_state == S_FETCH) && bus.mem_ack;
    assign w_issue_fire = (r_state == S_ISSUE) && bus.issue_ready;

    // start only takes effect from a parked state; busy states ignore it
    always_comb begin
        w_restart = 1'b0;
        case (r_state)
            S_IDLE, S_HALT: w_restart = start;
`ifdef FETCH_SEQUENCER_SINGLE_STEP_EN
            S_PAUSE:        w_restart = start;
`endif
            default:        w_restart = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_FETCH;
            S_FETCH:  if (bus.mem_ack) w_next = S_DECODE;
            S_DECODE: w_next = bus.run_en ? S_ISSUE : S_HALT;
            S_ISSUE: begin
                if (bus.issue_ready) begin
`ifdef FETCH_SEQUENCER_SINGLE_STEP_EN
                    w_next = S_PAUSE;
`else
                    w_next = S_FETCH;
`endif
                end
            end
            S_HALT:   if (start) w_next = S_FETCH;
`ifdef FETCH_SEQUENCER_SINGLE_STEP_EN
            S_PAUSE:  if (start || step) w_next = S_FETCH;
`endif
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.mem_req     = 1'b0;
        bus.issue_valid = 1'b0;
        halted          = 1'b0;
        busy            = 1'b0;
        case (r_state)
            S_FETCH:  begin bus.mem_req = 1'b1;     busy = 1'b1; end
            S_DECODE: busy = 1'b1;
            S_ISSUE:  begin bus.issue_valid = 1'b1; busy = 1'b1; end
            S_HALT:   halted = 1'b1;
            default:  ;
        endcase
    end

    // pc stays on the halt instruction because it only advances on a transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_opcode      <= '0;
            r_operand     <= '0;
            r_issue_count <= '0;
        end else begin
            if (w_restart) begin
                r_pc          <= RESET_PC;
                r_issue_count <= '0;
            end else if (w_issue_fire) begin
                r_pc          <= r_pc + ADDR_WIDTH'(1);
                r_issue_count <= sat_inc16(r_issue_count);
            end
            if (w_fetch_done) begin
                r_opcode  <= bus.mem_rdata[OPCODE_SIZE+OPERAND_SIZE-1:OPERAND_SIZE];
                r_operand <= bus.mem_rdata[OPERAND_SIZE-1:0];
            end
        end
    end

    assign bus.mem_addr = r_pc;
    assign bus.opcode   = r_opcode;
    assign bus.operand  = r_operand;
    assign pc           = r_pc;
    assign issue_count  = r_issue_count;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: random programs, random memory/ready
// latencies, reference model in plain array/queue form.
`timescale 1ns/1ps
module tb_fetch_sequencer;
    localparam int         AW      = 8;
    localparam int         OW      = 8;
    localparam int         DW      = 8;
    localparam logic [7:0] RPC     = 8'hFE;
    localparam logic [7:0] HALT_OP = 8'h01;

    typedef struct packed {
        logic [7:0] pc;
        logic [7:0] op;
        logic [7:0] opd;
    } item_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  pc;
    logic        halted;
    logic        busy;
    logic [15:0] issue_count;

    fetch_sequencer_if #(.ADDR_WIDTH(AW), .OPCODE_SIZE(OW), .OPERAND_SIZE(DW)) bus ();

`ifdef FETCH_SEQUENCER_SINGLE_STEP_EN
    logic step = 1'b0;
    bit   auto_step = 1'b1;
    bit   man_step = 1'b0;
`endif

    fetch_sequencer #(.ADDR_WIDTH(AW), .OPCODE_SIZE(OW), .OPERAND_SIZE(DW), .RESET_PC(RPC)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
`ifdef FETCH_SEQUENCER_SINGLE_STEP_EN
        .step(step),
`endif
        .bus(bus),
        .pc(pc),
        .halted(halted),
        .busy(busy),
        .issue_count(issue_count)
    );

    always #5 clk = ~clk;

    // halt detector stand-in: opcode 0x01 halts
    assign bus.run_en = (bus.opcode != HALT_OP);

    logic [15:0] mem [256];
    item_t       exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          exp_cnt;
    logic [7:0]  exp_pc;
    int          cyc_n = 0;
    int          last_fire = 0;
    int          last_gap = 0;

    int  mem_wait_max = 0;
    int  rdy_wait_max = 0;
    bit  fixed_wait = 1'b1;
    bit  inject = 1'b0;
    int  mcnt = 0;
    int  rcnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic int new_wait(input int mx);
        return fixed_wait ? mx : int'($urandom_range(0, mx));
    endfunction

    always @(posedge clk) cyc_n <= cyc_n + 1;

    // memory and execution-driver responders, updated just after each edge
    initial begin
        bus.mem_ack = 1'b0;
        bus.mem_rdata = '0;
        bus.issue_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (inject) begin
                bus.mem_ack = 1'b1;
                bus.mem_rdata = 16'($urandom);
            end else if (bus.mem_req) begin
                if (mcnt == 0) begin
                    bus.mem_ack = 1'b1;
                    bus.mem_rdata = mem[bus.mem_addr];
                end else begin
                    bus.mem_ack = 1'b0;
                    mcnt--;
                end
            end else begin
                bus.mem_ack = 1'($urandom_range(0, 1));
                bus.mem_rdata = 16'($urandom);
                mcnt = new_wait(mem_wait_max);
            end
            if (bus.issue_valid) begin
                if (rcnt == 0) bus.issue_ready = 1'b1;
                else begin
                    bus.issue_ready = 1'b0;
                    rcnt--;
                end
            end else begin
                bus.issue_ready = 1'($urandom_range(0, 1));
                rcnt = new_wait(rdy_wait_max);
            end
`ifdef FETCH_SEQUENCER_SINGLE_STEP_EN
            step = auto_step ? (!busy && !halted) : man_step;
`endif
        end
    end

    // monitor: pops the scoreboard on every accepted issue, checks handshake stability
    logic       p_req = 1'b0, p_ack = 1'b0, p_vld = 1'b0, p_rdy = 1'b0, p_rst = 1'b1;
    logic [7:0] p_addr = '0, p_op = '0, p_opd = '0;
    always @(negedge clk) begin
        item_t e;
        if (!rst) begin
            if (bus.issue_valid && bus.issue_ready) begin
                last_gap = cyc_n - last_fire;
                last_fire = cyc_n;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_issue: got op=0x%0h pc=0x%0h expected no issue", bus.opcode, pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("issue_opcode", 32'(bus.opcode), 32'(e.op));
                    chk("issue_operand", 32'(bus.operand), 32'(e.opd));
                    chk("issue_pc", 32'(pc), 32'(e.pc));
                end
            end
            if (bus.mem_req && p_req && !p_ack && !p_rst)
                chk("mem_addr_stable", 32'(bus.mem_addr), 32'(p_addr));
            if (bus.issue_valid && p_vld && !p_rdy && !p_rst) begin
                chk("opcode_stable", 32'(bus.opcode), 32'(p_op));
                chk("operand_stable", 32'(bus.operand), 32'(p_opd));
            end
        end
        p_req = bus.mem_req;   p_ack = bus.mem_ack;   p_addr = bus.mem_addr;
        p_vld = bus.issue_valid; p_rdy = bus.issue_ready;
        p_op = bus.opcode;     p_opd = bus.operand;   p_rst = rst;
    end

    // reference: walk memory from RESET_PC, every non-halt word issues in order
    task automatic run_model();
        logic [7:0] p;
        int k;
        p = RPC;
        k = 0;
        exp_cnt = 0;
        while (mem[p][15:8] != HALT_OP && k < 256) begin
            exp_q.push_back({p, mem[p][15:8], mem[p][7:0]});
            p = p + 8'd1;
            k++;
            exp_cnt++;
        end
        exp_pc = p;
    endtask

    task automatic load_prog(input int n);
        logic [7:0] a;
        logic [7:0] op;
        for (int i = 0; i < n; i++) begin
            a = RPC + 8'(i);
            do op = 8'($urandom); while (op == HALT_OP);
            mem[a] = {op, 8'($urandom)};
        end
        a = RPC + 8'(n);
        mem[a] = {HALT_OP, 8'($urandom)};
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
        @(negedge clk);
        chk("start_mem_req", 32'(bus.mem_req), 32'd1);
        chk("start_mem_addr", 32'(bus.mem_addr), 32'(RPC));
        chk("start_count_clear", 32'(issue_count), 32'd0);
    endtask

    task automatic wait_halt();
        int n;
        n = 0;
        while (!halted && n < 3000) begin
            cyc();
            n++;
        end
        chk("halt_reached", 32'(halted), 32'd1);
    endtask

    task automatic check_end(input string tag);
        @(negedge clk);
        chk({tag, "_pc"}, 32'(pc), 32'(exp_pc));
        chk({tag, "_count"}, 32'(issue_count), 32'(exp_cnt));
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        rst = 1'b1;
        repeat (3) cyc();
        @(negedge clk);
        chk("rst_pc", 32'(pc), 32'(RPC));
        chk("rst_opcode", 32'(bus.opcode), 32'd0);
        chk("rst_operand", 32'(bus.operand), 32'd0);
        chk("rst_count", 32'(issue_count), 32'd0);
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_issue_valid", 32'(bus.issue_valid), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        cyc();
        rst = 1'b0;
        repeat (2) cyc();

        // basic run across the 0xFF->0x00 wrap, zero-wait memory, ready immediate
        mem[8'hFE] = 16'h10AA;
        mem[8'hFF] = 16'h20BB;
        mem[8'h00] = 16'h0100;
        mem[8'h01] = 16'h30CC;
        fixed_wait = 1'b1; mem_wait_max = 0; rdy_wait_max = 0;
        run_model();
        do_start();
        wait_halt();
        check_end("basic");
        chk("basic_halt_pc", 32'(pc), 32'h00);
        chk("basic_issue_gap", 32'(last_gap), 32'd3);

        // fixed wait states
        load_prog(6);
        fixed_wait = 1'b1; mem_wait_max = 3; rdy_wait_max = 2;
        run_model();
        do_start();
        wait_halt();
        check_end("waits");

        // random programs and latencies, restarting from HALT each time
        fixed_wait = 1'b0; mem_wait_max = 3; rdy_wait_max = 3;
        for (int r = 0; r < 6; r++) begin
            load_prog(int'($urandom_range(1, 10)));
            run_model();
            do_start();
            if (r == 2) begin
                repeat (4) cyc();
                if (busy) begin
                    start = 1'b1;
                    cyc();
                    start = 1'b0;
                end
            end
            wait_halt();
            check_end("rand");
        end

        // reset in FETCH after one issue, then a stray ack
        load_prog(4);
        fixed_wait = 1'b1; mem_wait_max = 5; rdy_wait_max = 0;
        run_model();
        do_start();
        n = 0;
        while (!(issue_count == 16'd1 && bus.mem_req) && n < 500) begin
            cyc();
            n++;
        end
        chk("midfetch_reached", 32'(bus.mem_req), 32'd1);
        rst = 1'b1;
        cyc();
        exp_q.delete();
        rst = 1'b0;
        inject = 1'b1;
        @(negedge clk);
        chk("midrst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_pc", 32'(pc), 32'(RPC));
        chk("midrst_count", 32'(issue_count), 32'd0);
        repeat (3) cyc();
        inject = 1'b0;
        @(negedge clk);
        chk("late_ack_busy", 32'(busy), 32'd0);
        chk("late_ack_valid", 32'(bus.issue_valid), 32'd0);
        chk("late_ack_count", 32'(issue_count), 32'd0);

        // start from IDLE after the reset
        fixed_wait = 1'b0; mem_wait_max = 2; rdy_wait_max = 2;
        load_prog(5);
        run_model();
        do_start();
        wait_halt();
        check_end("after_rst");

`ifdef FETCH_SEQUENCER_SINGLE_STEP_EN
        auto_step = 1'b0;
        fixed_wait = 1'b1; mem_wait_max = 0; rdy_wait_max = 0;
        load_prog(3);
        run_model();
        do_start();
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while ((busy || halted) && n < 200) begin
                cyc();
                n++;
            end
            chk("step_pause_busy", 32'(busy), 32'd0);
            chk("step_pause_count", 32'(issue_count), 32'(k + 1));
            repeat (2) cyc();
            chk("step_still_paused", 32'(busy), 32'd0);
            man_step = 1'b1;
            cyc();
            man_step = 1'b0;
        end
        wait_halt();
        check_end("step");
        auto_step = 1'b1;
`endif

        repeat (3) cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
